// File: rtl/param_accumulator_if.sv
// Host-side bus of the accumulator: word loading, start/clear control and the
// reduction status returned by the block.
interface param_accumulator_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             start;
  logic             clear;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             overflow;
  logic [CW-1:0]    count;

  modport master (
    output load_valid, load_data, start, clear,
    input  load_ready, busy, done, result, overflow, count
  );

  modport slave (
    input  load_valid, load_data, start, clear,
    output load_ready, busy, done, result, overflow, count
  );
endinterface

// File: rtl/param_accumulator.sv
// Pool-based reduction: the host fills a circular pool, then NPROC adder workers
// repeatedly pop two entries and push their sum back until one entry remains.
module param_accumulator #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 1024,
  parameter int NPROC   = 4,
  parameter int ADD_LAT = 1,
  parameter int SAT     = 0
) (
  input logic               clk,
  input logic               reset,
  param_accumulator_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int GW = (NPROC > 1) ? $clog2(NPROC) : 1;

  typedef enum logic [1:0] {PH_LOAD, PH_RUN, PH_DONE} phase_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT_POP, W_ADD, W_WAIT_PUSH} wstate_t;

  phase_t           phase;
  wstate_t          wstate   [NPROC];
  logic [WIDTH-1:0] a_q      [NPROC];
  logic [WIDTH-1:0] b_q      [NPROC];
  logic [WIDTH-1:0] sum_q    [NPROC];
  logic [3:0]       lat_q    [NPROC];
  logic [WIDTH:0]   wide_sum [NPROC];
  logic [WIDTH-1:0] pool     [DEPTH];

  logic [PW-1:0]    head, tail;
  logic [CW-1:0]    count;
  logic [GW-1:0]    last_grant, grant_idx, cand;
  logic [NPROC-1:0] eligible;
  logic             grant_valid, in_flight, terminate;
  logic [WIDTH-1:0] result_q;
  logic             overflow_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  // Termination only once nothing is in flight and at most one value is left.
  always_comb begin
    eligible  = '0;
    in_flight = 1'b0;
    for (int i = 0; i < NPROC; i++) begin
      wide_sum[i] = {1'b0, a_q[i]} + {1'b0, b_q[i]};
      if (phase == PH_RUN &&
          ((wstate[i] == W_WAIT_POP && count >= CW'(2)) || wstate[i] == W_WAIT_PUSH))
        eligible[i] = 1'b1;
      if (wstate[i] == W_ADD || wstate[i] == W_WAIT_PUSH)
        in_flight = 1'b1;
    end
    terminate = (phase == PH_RUN) && !in_flight && (count <= CW'(1));
  end

  // Round-robin search begins just after the most recent grant.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = last_grant;
    cand        = '0;
    for (int k = 1; k <= NPROC; k++) begin
      cand = GW'((int'(last_grant) + k) % NPROC);
      if (!grant_valid && eligible[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase      <= PH_LOAD;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      last_grant <= GW'(NPROC - 1);
      result_q   <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < NPROC; i++) begin
        wstate[i] <= W_IDLE;
        a_q[i]    <= '0;
        b_q[i]    <= '0;
        sum_q[i]  <= '0;
        lat_q[i]  <= '0;
      end
    end else begin
      case (phase)
        PH_LOAD: begin
          if (bus.load_valid && bus.load_ready) begin
            pool[tail] <= bus.load_data;
            tail       <= ptr_inc(tail);
            count      <= count + 1'b1;
          end
          if (bus.start) phase <= PH_RUN;
        end
        PH_RUN: begin
          if (terminate) begin
            phase    <= PH_DONE;
            result_q <= (count == '0) ? '0 : pool[head];
          end
        end
        PH_DONE: begin
          if (bus.clear) begin
            phase      <= PH_LOAD;
            count      <= '0;
            head       <= tail;
            result_q   <= '0;
            overflow_q <= 1'b0;
          end
        end
        default: phase <= PH_LOAD;
      endcase

      // Only one worker is granted per cycle, so the pool sees one pop-two or one push.
      if (grant_valid) begin
        last_grant <= grant_idx;
        if (wstate[grant_idx] == W_WAIT_POP) begin
          head  <= ptr_inc(ptr_inc(head));
          count <= count - CW'(2);
        end else begin
          pool[tail] <= sum_q[grant_idx];
          tail       <= ptr_inc(tail);
          count      <= count + 1'b1;
        end
      end

      for (int i = 0; i < NPROC; i++) begin
        case (wstate[i])
          W_IDLE:
            if (phase == PH_RUN && !terminate) wstate[i] <= W_WAIT_POP;
          W_WAIT_POP: begin
            if (terminate || phase != PH_RUN) begin
              wstate[i] <= W_IDLE;
            end else if (grant_valid && grant_idx == GW'(i)) begin
              a_q[i]    <= pool[head];
              b_q[i]    <= pool[ptr_inc(head)];
              lat_q[i]  <= 4'(ADD_LAT - 1);
              wstate[i] <= W_ADD;
            end
          end
          W_ADD: begin
            if (lat_q[i] == '0) begin
              sum_q[i]  <= (SAT != 0 && wide_sum[i][WIDTH]) ? {WIDTH{1'b1}}
                                                            : wide_sum[i][WIDTH-1:0];
              if (wide_sum[i][WIDTH]) overflow_q <= 1'b1;
              wstate[i] <= W_WAIT_PUSH;
            end else begin
              lat_q[i] <= lat_q[i] - 1'b1;
            end
          end
          W_WAIT_PUSH:
            if (grant_valid && grant_idx == GW'(i))
              wstate[i] <= (phase == PH_RUN) ? W_WAIT_POP : W_IDLE;
          default: wstate[i] <= W_IDLE;
        endcase
      end
    end
  end

  assign bus.load_ready = (phase == PH_LOAD) && (count < CW'(DEPTH));
  assign bus.busy       = (phase == PH_RUN);
  assign bus.done       = (phase == PH_DONE);
  assign bus.result     = result_q;
  assign bus.overflow   = overflow_q;
  assign bus.count      = count;
endmodule

// File: tb/tb_param_accumulator.sv
// Scoreboard bench: each reduction pushes its expected outcome, and per-instance
// monitors pop and compare when done rises.
module tb_param_accumulator;
  localparam int MW = 16;
  localparam int MD = 64;
  localparam int MN = 4;
  localparam int SW = 8;
  localparam int SD = 8;

  typedef struct {
    logic [15:0] result;
    logic        overflow;
    int          count;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  param_accumulator_if #(.WIDTH(MW), .DEPTH(MD)) main_bus ();
  param_accumulator_if #(.WIDTH(SW), .DEPTH(SD)) wrap_bus ();
  param_accumulator_if #(.WIDTH(SW), .DEPTH(SD)) sat_bus ();

  param_accumulator #(.WIDTH(MW), .DEPTH(MD), .NPROC(MN), .ADD_LAT(3), .SAT(0))
    dut_main (.clk(clk), .reset(reset), .bus(main_bus));
  param_accumulator #(.WIDTH(SW), .DEPTH(SD), .NPROC(2), .ADD_LAT(1), .SAT(0))
    dut_wrap (.clk(clk), .reset(reset), .bus(wrap_bus));
  param_accumulator #(.WIDTH(SW), .DEPTH(SD), .NPROC(2), .ADD_LAT(1), .SAT(1))
    dut_sat (.clk(clk), .reset(reset), .bus(sat_bus));

  exp_t main_q[$];
  exp_t wrap_q[$];
  exp_t sat_q[$];
  int   checks = 0;
  int   errors = 0;
  int   grants[MN] = '{default: 0};
  int   wait_cnt[MN] = '{default: 0};
  int   max_wait = 0;
  int   cyc;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got no response, expected one", name);
  endtask

  task automatic applyStimulus(input logic valid, input logic [15:0] data,
                               input logic st, input logic clr);
    main_bus.load_valid = valid;
    main_bus.load_data  = data;
    main_bus.start      = st;
    main_bus.clear      = clr;
    @(posedge clk); #1;
    main_bus.load_valid = 1'b0;
    main_bus.start      = 1'b0;
    main_bus.clear      = 1'b0;
  endtask

  task automatic applySmall(input logic valid, input logic [7:0] data,
                            input logic st, input logic clr);
    wrap_bus.load_valid = valid; sat_bus.load_valid = valid;
    wrap_bus.load_data  = data;  sat_bus.load_data  = data;
    wrap_bus.start      = st;    sat_bus.start      = st;
    wrap_bus.clear      = clr;   sat_bus.clear      = clr;
    @(posedge clk); #1;
    wrap_bus.load_valid = 1'b0; sat_bus.load_valid = 1'b0;
    wrap_bus.start      = 1'b0; sat_bus.start      = 1'b0;
    wrap_bus.clear      = 1'b0; sat_bus.clear      = 1'b0;
  endtask

  task automatic waitMainDone(input int budget, output int cycles);
    cycles = 0;
    while (main_bus.done !== 1'b1 && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    if (main_bus.done !== 1'b1) reportFail("main_done_timeout");
  endtask

  task automatic waitSmallDone(input int budget);
    int cycles = 0;
    while (!(wrap_bus.done === 1'b1 && sat_bus.done === 1'b1) && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    if (!(wrap_bus.done === 1'b1 && sat_bus.done === 1'b1)) reportFail("small_done_timeout");
  endtask

  task automatic clearMain();
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("clear_count", 32'(main_bus.count), 32'd0);
    checkOutput("clear_done", 32'(main_bus.done), 32'd0);
    checkOutput("clear_busy", 32'(main_bus.busy), 32'd0);
    checkOutput("clear_load_ready", 32'(main_bus.load_ready), 32'd1);
    checkOutput("clear_result", 32'(main_bus.result), 32'd0);
  endtask

  task automatic clearSmall();
    applySmall(1'b0, 8'h0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("wrap_clear_overflow", 32'(wrap_bus.overflow), 32'd0);
    checkOutput("sat_clear_overflow", 32'(sat_bus.overflow), 32'd0);
    checkOutput("wrap_clear_count", 32'(wrap_bus.count), 32'd0);
  endtask

  // Main monitor also confirms busy hands over to done on the same edge.
  logic main_prev_done = 1'b0, main_prev_busy = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (main_bus.done === 1'b1 && main_prev_done !== 1'b1) begin
      if (main_q.size() == 0) reportFail("main_unexpected_done");
      else begin
        e = main_q.pop_front();
        checkOutput("main_result", 32'(main_bus.result), 32'(e.result));
        checkOutput("main_overflow", 32'(main_bus.overflow), 32'(e.overflow));
        checkOutput("main_count", 32'(main_bus.count), 32'(e.count));
        checkOutput("main_busy_handoff", {30'd0, main_prev_busy, main_bus.busy}, 32'd2);
      end
    end
    main_prev_done = main_bus.done;
    main_prev_busy = main_bus.busy;
  end

  logic wrap_prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (wrap_bus.done === 1'b1 && wrap_prev_done !== 1'b1) begin
      if (wrap_q.size() == 0) reportFail("wrap_unexpected_done");
      else begin
        e = wrap_q.pop_front();
        checkOutput("wrap_result", 32'(wrap_bus.result), 32'(e.result));
        checkOutput("wrap_overflow", 32'(wrap_bus.overflow), 32'(e.overflow));
        checkOutput("wrap_count", 32'(wrap_bus.count), 32'(e.count));
      end
    end
    wrap_prev_done = wrap_bus.done;
  end

  logic sat_prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (sat_bus.done === 1'b1 && sat_prev_done !== 1'b1) begin
      if (sat_q.size() == 0) reportFail("sat_unexpected_done");
      else begin
        e = sat_q.pop_front();
        checkOutput("sat_result", 32'(sat_bus.result), 32'(e.result));
        checkOutput("sat_overflow", 32'(sat_bus.overflow), 32'(e.overflow));
        checkOutput("sat_count", 32'(sat_bus.count), 32'(e.count));
      end
    end
    sat_prev_done = sat_bus.done;
  end

  // Grant observer: counts how many other grants each eligible worker sits through.
  always @(negedge clk) begin
    for (int i = 0; i < MN; i++) begin
      if (reset) begin
        wait_cnt[i] = 0;
      end else if (dut_main.grant_valid && int'(dut_main.grant_idx) == i) begin
        grants[i]++;
        wait_cnt[i] = 0;
      end else if (dut_main.eligible[i]) begin
        if (dut_main.grant_valid) begin
          wait_cnt[i]++;
          if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
        end
      end else begin
        wait_cnt[i] = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected one");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    main_bus.load_valid = 1'b0; main_bus.load_data = '0;
    main_bus.start = 1'b0;      main_bus.clear = 1'b0;
    wrap_bus.load_valid = 1'b0; wrap_bus.load_data = '0;
    wrap_bus.start = 1'b0;      wrap_bus.clear = 1'b0;
    sat_bus.load_valid = 1'b0;  sat_bus.load_data = '0;
    sat_bus.start = 1'b0;       sat_bus.clear = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_busy", 32'(main_bus.busy), 32'd0);
    checkOutput("reset_done", 32'(main_bus.done), 32'd0);
    checkOutput("reset_result", 32'(main_bus.result), 32'd0);
    checkOutput("reset_overflow", 32'(main_bus.overflow), 32'd0);
    checkOutput("reset_load_ready", 32'(main_bus.load_ready), 32'd1);
    checkOutput("reset_count", 32'(main_bus.count), 32'd0);

    $display("[TB] empty pool reduction");
    main_q.push_back('{result: 16'h0, overflow: 1'b0, count: 0});
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    waitMainDone(10, cyc);
    checkOutput("empty_latency", 32'(cyc), 32'd2);
    clearMain();

    $display("[TB] single word loaded with start");
    main_q.push_back('{result: 16'h1234, overflow: 1'b0, count: 1});
    applyStimulus(1'b1, 16'h1234, 1'b1, 1'b0);
    waitMainDone(20, cyc);
    clearMain();

    $display("[TB] sum of 1..10");
    main_q.push_back('{result: 16'd55, overflow: 1'b0, count: 1});
    for (int v = 1; v <= 10; v++) applyStimulus(1'b1, 16'(v), 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    waitMainDone(500, cyc);
    clearMain();

    $display("[TB] overfill pool with DEPTH+3 ones");
    for (int v = 0; v < MD + 3; v++) applyStimulus(1'b1, 16'd1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("full_load_ready", 32'(main_bus.load_ready), 32'd0);
    checkOutput("full_count", 32'(main_bus.count), 32'(MD));
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("clear_in_load_ignored", 32'(main_bus.count), 32'(MD));
    main_q.push_back('{result: 16'(MD), overflow: 1'b0, count: 1});
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    waitMainDone(3000, cyc);
    clearMain();

    $display("[TB] reset during a reduction");
    for (int v = 1; v <= 3; v++) applyStimulus(1'b1, 16'(v), 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    repeat (4) applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("midrun_busy", 32'(main_bus.busy), 32'd1);
    main_bus.load_valid = 1'b1; main_bus.load_data = 16'd99;
    main_bus.start = 1'b1;      reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; main_bus.load_valid = 1'b0; main_bus.start = 1'b0;
    @(negedge clk);
    checkOutput("midrun_reset_busy", 32'(main_bus.busy), 32'd0);
    checkOutput("midrun_reset_done", 32'(main_bus.done), 32'd0);
    checkOutput("midrun_reset_count", 32'(main_bus.count), 32'd0);
    checkOutput("midrun_reset_load_ready", 32'(main_bus.load_ready), 32'd1);
    checkOutput("midrun_reset_result", 32'(main_bus.result), 32'd0);
    main_q.push_back('{result: 16'h0, overflow: 1'b0, count: 0});
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    waitMainDone(10, cyc);
    clearMain();
    main_q.push_back('{result: 16'd15, overflow: 1'b0, count: 1});
    applyStimulus(1'b1, 16'd7, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'd8, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    waitMainDone(200, cyc);
    clearMain();

    $display("[TB] 8-bit carry: wrap and saturate");
    wrap_q.push_back('{result: 16'd44, overflow: 1'b1, count: 1});
    sat_q.push_back('{result: 16'd255, overflow: 1'b1, count: 1});
    applySmall(1'b1, 8'd200, 1'b0, 1'b0);
    applySmall(1'b1, 8'd100, 1'b0, 1'b0);
    applySmall(1'b0, 8'd0, 1'b1, 1'b0);
    waitSmallDone(50);
    clearSmall();

    $display("[TB] 8-bit pool with pops across the wrap point");
    wrap_q.push_back('{result: 16'd15, overflow: 1'b0, count: 1});
    sat_q.push_back('{result: 16'd15, overflow: 1'b0, count: 1});
    for (int v = 1; v <= 5; v++) applySmall(1'b1, 8'(v), 1'b0, 1'b0);
    applySmall(1'b0, 8'd0, 1'b1, 1'b0);
    waitSmallDone(100);
    clearSmall();

    $display("[TB] 8-bit pool overfill");
    for (int v = 0; v < SD + 3; v++) applySmall(1'b1, 8'd1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("small_full_load_ready", 32'(wrap_bus.load_ready), 32'd0);
    checkOutput("small_full_count", 32'(wrap_bus.count), 32'(SD));
    wrap_q.push_back('{result: 16'(SD), overflow: 1'b0, count: 1});
    sat_q.push_back('{result: 16'(SD), overflow: 1'b0, count: 1});
    applySmall(1'b0, 8'd0, 1'b1, 1'b0);
    waitSmallDone(200);
    clearSmall();

    repeat (3) @(negedge clk);
    checkOutput("main_pending", 32'(main_q.size()), 32'd0);
    checkOutput("wrap_pending", 32'(wrap_q.size()), 32'd0);
    checkOutput("sat_pending", 32'(sat_q.size()), 32'd0);
    checkOutput("fair_wait_bound", 32'(max_wait <= MN - 1), 32'd1);
    for (int i = 0; i < MN; i++)
      checkOutput($sformatf("worker%0d_granted", i), 32'(grants[i] > 0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/param_accumulator.md
PARAM_ACCUMULATOR -- requirements
Module: param_accumulator

Interface
REQ-001 Parameter WIDTH, default 32: operand, sum and result width in bits.
REQ-002 Parameter DEPTH, default 1024: pool capacity in entries.
REQ-003 Parameter NPROC, default 4: number of adder workers sharing the pool.
REQ-004 Parameter ADD_LAT, default 1, range 1-8: cycles a worker spends in ADD.
REQ-005 Parameter SAT, default 0: 0 = sums wrap modulo 2^WIDTH; 1 = sums saturate to all-ones.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 load_valid  input  1  a host word is offered this cycle.
REQ-009 load_data  input  WIDTH  the host word.
REQ-010 load_ready  output  1  high when in LOAD and pool count < DEPTH.
REQ-011 start  input  1  single-cycle pulse that begins the reduction.
REQ-012 clear  input  1  returns the block from DONE to an empty LOAD.
REQ-013 busy  output  1  high while in RUN.
REQ-014 done  output  1  high while in DONE.
REQ-015 result  output  WIDTH  final sum while done=1, otherwise 0.
REQ-016 overflow  output  1  sticky flag; set when any addition produces an unsigned carry-out.
REQ-017 count  output  clog2(DEPTH+1)  current number of entries in the pool.

Function
REQ-018 Top-level phase FSM states: LOAD, RUN, DONE.
REQ-019 In LOAD, a word SHALL be written at the pool tail and count incremented when load_valid=1 and load_ready=1.
REQ-020 When count = DEPTH, load_valid SHALL be ignored and the word dropped.
REQ-021 start in LOAD SHALL move the phase to RUN on the next cycle; a load accepted in the same cycle is included in the reduction.
REQ-022 start in RUN or DONE, and load_valid outside LOAD, SHALL be ignored.
REQ-023 Each worker SHALL run the FSM IDLE -> WAIT_POP -> ADD -> WAIT_PUSH -> IDLE.
REQ-024 In RUN, an IDLE worker SHALL enter WAIT_POP on the next cycle.
REQ-025 A worker is eligible for a grant when it is in WAIT_POP with count >= 2, or when it is in WAIT_PUSH.
REQ-026 A round-robin arbiter SHALL grant at most one eligible worker per cycle; the search starts at last_grant+1 modulo NPROC.
REQ-027 The arbiter pointer SHALL update only on a grant; its reset value is NPROC-1, so worker 0 has first priority.
REQ-028 A WAIT_POP grant SHALL, in the same cycle, pop the two head entries into that worker's A and B registers (count -= 2). The worker then enters ADD.
REQ-029 The worker SHALL remain in ADD for exactly ADD_LAT cycles, then enter WAIT_PUSH holding sum = A + B.
REQ-030 Arithmetic: the WIDTH+1-bit sum's carry SHALL set overflow.
REQ-031 The stored sum is the low WIDTH bits when SAT=0, or all-ones on carry when SAT=1.
REQ-032 A WAIT_PUSH grant SHALL write the sum at the pool tail (count += 1). The worker then returns to IDLE, or to WAIT_POP if the phase is still RUN.
REQ-033 Head and tail pointers SHALL wrap modulo DEPTH; a pop-two across the wrap boundary SHALL read the entries at index DEPTH-1 and index 0.
REQ-034 Termination: in RUN, when count <= 1 and no worker is in ADD or WAIT_PUSH, the phase SHALL move to DONE on the next cycle.
REQ-035 On entering DONE, workers in WAIT_POP SHALL return to IDLE.
REQ-036 In DONE, result SHALL equal the head entry, or 0 if count = 0; it is held stable until clear or reset.
REQ-037 clear in DONE SHALL empty the pool (count = 0) and return to LOAD on the next cycle, leaving overflow cleared. clear in any other phase SHALL be ignored.
REQ-038 A grant and a termination check in the same cycle: termination is evaluated on the post-grant state of the following cycle.

Reset
REQ-039 Reset asserted at a rising edge SHALL, in any phase, set phase=LOAD, all workers IDLE, head=tail=0, count=0 and arbiter pointer=NPROC-1.
REQ-040 After reset the outputs SHALL be: busy=0, done=0, result=0, overflow=0, load_ready=1.
REQ-041 Reset SHALL override start, clear and load_valid asserted in the same cycle, and SHALL abandon any in-flight reduction without a partial result.

Verification
REQ-042 Load 1..10, pulse start -> done=1 and result=55, overflow=0, count=1; busy drops in the same cycle done rises.
REQ-043 Start with an empty pool -> done on the second cycle with result=0. Load the single value 0x1234, start -> done with result=0x1234.
REQ-044 WIDTH=8, load 200 and 100, start -> result=44 with overflow=1. Repeat with SAT=1 -> result=255 with overflow=1.
REQ-045 Load DEPTH+3 words of 1 -> load_ready low after DEPTH accepts, count=DEPTH, the extra 3 words dropped; start -> result=DEPTH (mod 2^WIDTH).
REQ-046 NPROC=4, 64 words of 1, ADD_LAT=3 -> result=64. Every worker is granted at least once, and no worker is granted twice while another eligible worker waits longer than NPROC-1 grants.
REQ-047 Assert reset mid-RUN, then assert clear in DONE -> next cycle count=0, busy=0, done=0, load_ready=1. A subsequent load of 7,8 and start -> result=15.
